// File: rtl/memarb_pkg.sv
// +----------------------------------------------------------------------------+
// | memarb_pkg : shared types, default sizes and helpers for the SRAM arbiter  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package memarb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int c_nch_default = 4;
  localparam int c_aw_default  = 19;
  localparam int c_dw_default  = 8;
  localparam int c_max_nch     = 8;

  // Highest set bit wins; callers only pass one-hot vectors.
  function automatic logic [2:0] onehot_to_idx(input logic [c_max_nch-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < c_max_nch; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/memarb_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | memarb_rr_arbiter : fixed-priority low channels plus round-robin remainder |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module memarb_rr_arbiter
  import memarb_pkg::*;
#(
  parameter int NCH  = c_nch_default,
  parameter int NFIX = 1
) (
  input  logic           clk28,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           take,
  output logic [NCH-1:0] gnt
);

  localparam int c_pw = $clog2(NCH);

  logic [c_pw-1:0] r_ptr;
  logic [NCH-1:0]  w_fix;
  logic [NCH-1:0]  w_rr;
  logic [2:0]      w_rr_win;
  int              w_rr_idx;

  always_comb begin
    w_fix    = '0;
    w_rr     = '0;
    w_rr_idx = 0;
    // Descending scans so the last hit (lowest index / nearest to pointer) sticks.
    for (int i = NFIX - 1; i >= 0; i--) begin
      if (req[i]) w_fix = NCH'(1) << i;
    end
    for (int k = NCH - NFIX - 1; k >= 0; k--) begin
      w_rr_idx = int'(r_ptr) + k;
      if (w_rr_idx >= NCH) w_rr_idx = w_rr_idx - (NCH - NFIX);
      if (req[w_rr_idx]) w_rr = NCH'(1) << w_rr_idx;
    end
  end

  assign gnt      = (|w_fix) ? w_fix : w_rr;
  assign w_rr_win = onehot_to_idx(c_max_nch'(w_rr));

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_ptr <= c_pw'(NFIX);
    end else if (take && !(|w_fix) && (|w_rr)) begin
      if (int'(w_rr_win) == NCH - 1) r_ptr <= c_pw'(NFIX);
      else                           r_ptr <= c_pw'(int'(w_rr_win) + 1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// +----------------------------------------------------------------------------+
// | sram_arbiter : multi-channel async SRAM sequencer with timed strobes       |
// | Optional locked bursts with MEMARB_BURST_EN.  Rev 1.0                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module sram_arbiter
  import memarb_pkg::*;
#(
  parameter int NCH      = c_nch_default,
  parameter int NFIX     = 1,
  parameter int AW       = c_aw_default,
  parameter int DW       = c_dw_default,
  parameter int WAIT     = 1,
  parameter int MAXBURST = 2
) (
  input  logic              clk28,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH-1:0]    lock,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  output logic [NCH-1:0]    gnt,
  output logic [NCH-1:0]    rvalid,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic [AW-1:0]     va,
  input  logic [DW-1:0]     vd_in,
  output logic [DW-1:0]     vd_out,
  output logic              vd_oe,
  output logic              n_vrd,
  output logic              n_vwr
);

  localparam int c_iw = $clog2(NCH);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_wcnt;
  logic [c_iw-1:0] r_ch;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [NCH-1:0]  r_gnt;
  logic [NCH-1:0]  r_rvalid;
  logic [DW-1:0]   r_rdata;
  logic [AW-1:0]   r_va;
  logic [DW-1:0]   r_vd_out;
  logic            r_vd_oe;
  logic            r_n_vrd;
  logic            r_n_vwr;

  logic [NCH-1:0]  w_arb_gnt;
  logic [NCH-1:0]  w_new_gnt;
  logic [c_iw-1:0] w_new_idx;
  logic            w_take;
  logic            w_burst_ok;

  memarb_rr_arbiter #(
    .NCH  (NCH),
    .NFIX (NFIX)
  ) u_arb (
    .clk28 (clk28),
    .rst   (rst),
    .req   (req),
    .take  (w_take),
    .gnt   (w_arb_gnt)
  );

`ifdef MEMARB_BURST_EN
  logic [7:0] r_beats;

  assign w_burst_ok = lock[r_ch] && req[r_ch] && (r_beats < 8'(MAXBURST));

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst)                                r_beats <= 8'd0;
    else if (w_take)                        r_beats <= 8'd1;
    else if (r_state == HOLD && w_burst_ok) r_beats <= r_beats + 8'd1;
  end
`else
  logic w_unused_cfg;

  assign w_burst_ok   = 1'b0;
  assign w_unused_cfg = ^{lock, 8'(MAXBURST)};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_new_gnt   = '0;
    case (r_state)
      IDLE: begin
        if (|w_arb_gnt) begin
          w_take      = 1'b1;
          w_new_gnt   = w_arb_gnt;
          w_state_nxt = ADDR;
        end
      end
      ADDR:   w_state_nxt = STROBE;
      STROBE: if (r_wcnt == 3'(WAIT)) w_state_nxt = HOLD;
      HOLD: begin
        if (w_burst_ok) begin
          w_new_gnt   = NCH'(1) << r_ch;
          w_state_nxt = ADDR;
        end else if (|w_arb_gnt) begin
          w_take      = 1'b1;
          w_new_gnt   = w_arb_gnt;
          w_state_nxt = ADDR;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_new_idx = c_iw'(onehot_to_idx(c_max_nch'(w_new_gnt)));

  // Pins follow the state one cycle late, so HOLD pins still see the old
  // access while the next request is already being latched.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wcnt   <= 3'd0;
      r_ch     <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_va     <= '0;
      r_vd_out <= '0;
      r_vd_oe  <= 1'b0;
      r_n_vrd  <= 1'b1;
      r_n_vwr  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_new_gnt;
      r_rvalid <= '0;
      r_wcnt   <= (r_state == STROBE) ? r_wcnt + 3'd1 : 3'd0;
      if (|w_new_gnt) begin
        r_ch    <= w_new_idx;
        r_we    <= we[w_new_idx];
        r_addr  <= addr[w_new_idx*AW +: AW];
        r_wdata <= wdata[w_new_idx*DW +: DW];
      end
      case (r_state)
        IDLE: begin
          r_vd_oe <= 1'b0;
          r_n_vrd <= 1'b1;
          r_n_vwr <= 1'b1;
        end
        ADDR: begin
          r_va    <= r_addr;
          r_vd_oe <= r_we;
          r_n_vrd <= r_we;
          r_n_vwr <= 1'b1;
          if (r_we) r_vd_out <= r_wdata;
        end
        STROBE: begin
          r_n_vrd <= r_we;
          r_n_vwr <= !r_we;
        end
        HOLD: begin
          r_n_vrd <= 1'b1;
          r_n_vwr <= 1'b1;
          if (!r_we) begin
            r_rdata  <= vd_in;
            r_rvalid <= NCH'(1) << r_ch;
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign busy   = (r_state != IDLE);
  assign va     = r_va;
  assign vd_out = r_vd_out;
  assign vd_oe  = r_vd_oe;
  assign n_vrd  = r_n_vrd;
  assign n_vwr  = r_n_vwr;

endmodule

`default_nettype wire
